// File: rtl/rat_pkg.sv
// Shared RAT CPU definitions: program-address width and type, plus the
// per-cycle operation decode used by the return-address stack.
package rat_pkg;

    localparam int unsigned PC_W = 10;

    typedef logic [PC_W-1:0] pc_addr_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_OVF,
        OP_UNF
    } stack_op_e;

endpackage

// File: rtl/ret_stack_mem.sv
// DEPTH x PC_W single-write-port RAM with an asynchronous read port,
// sized and shaped to map onto distributed RAM.
module ret_stack_mem #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PC_W  = 10,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [PC_W-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [PC_W-1:0] o_rdata
);

    logic [PC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack feeding the PC mux: pushes PC+1 on CALL, exposes the
// top entry combinationally for RET/RETIE, and tracks sticky OVF/UNF errors.
module ret_addr_stack #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PC_W  = 10,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned SPW  = AW + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PUSH,
    input  logic            POP,
    input  logic [PC_W-1:0] PC_COUNT,
    output logic [PC_W-1:0] FROM_STACK,
    output logic [SPW-1:0]  SP,
    output logic            EMPTY,
    output logic            FULL,
    output logic            OVF,
    output logic            UNF
);

    import rat_pkg::*;

    localparam logic [SPW-1:0] SP_ONE = SPW'(1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [SPW-1:0]  r_sp;
    logic            r_ovf;
    logic            r_unf;

    stack_op_e       w_op;
    logic            w_empty;
    logic            w_full;
    logic [AW-1:0]   w_top_idx;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [PC_W-1:0] w_wdata;
    logic [PC_W-1:0] w_rdata;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_MAX);
    assign w_top_idx = r_sp[AW-1:0] - AW'(1);
    assign w_wdata   = PC_COUNT + PC_W'(1);

    // PUSH+POP on an empty stack degenerates to a plain push (no UNF);
    // on a non-empty stack it overwrites the top in place, even when full.
    always_comb begin
        w_op = OP_HOLD;
        unique case ({PUSH, POP})
            2'b10:   w_op = w_full  ? OP_OVF : OP_PUSH;
            2'b01:   w_op = w_empty ? OP_UNF : OP_POP;
            2'b11:   w_op = w_empty ? OP_PUSH : OP_REPLACE;
            default: w_op = OP_HOLD;
        endcase
    end

    assign w_we    = !RST && (w_op == OP_PUSH || w_op == OP_REPLACE);
    assign w_waddr = (w_op == OP_REPLACE) ? w_top_idx : r_sp[AW-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            unique case (w_op)
                OP_PUSH: r_sp  <= r_sp + SP_ONE;
                OP_POP:  r_sp  <= r_sp - SP_ONE;
                OP_OVF:  r_ovf <= 1'b1;
                OP_UNF:  r_unf <= 1'b1;
                default: ;
            endcase
        end
    end

    ret_stack_mem #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_top_idx),
        .o_rdata (w_rdata)
    );

    assign FROM_STACK = w_empty ? '0 : w_rdata;
    assign SP         = r_sp;
    assign EMPTY      = w_empty;
    assign FULL       = w_full;
    assign OVF        = r_ovf;
    assign UNF        = r_unf;

endmodule
